// File: rtl/packet_pkg.sv
// Wire-format constants and FSM encoding shared by the receive and transmit
// packet framers.
package packet_pkg;

    localparam logic [7:0] SYNC0_BYTE   = 8'h55;
    localparam logic [7:0] SYNC1_BYTE   = 8'hAA;
    localparam int         HEADER_BYTES = 7;

    localparam logic [1:0] ERR_NONE         = 2'd0;
    localparam logic [1:0] ERR_LEN_MISMATCH = 2'd1;
    localparam logic [1:0] ERR_LEN_RANGE    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT      = 2'd3;

    typedef enum logic [2:0] {
        ST_SYNC0,
        ST_SYNC1,
        ST_CMD,
        ST_LENA_H,
        ST_LENA_L,
        ST_LENB_H,
        ST_LENB_L,
        ST_PAYLOAD
    } state_e;

endpackage

// File: rtl/packet_rx.sv
// Receive-side packet framer: hunts for 55 AA, parses cmd and a duplicated
// length, collects a fixed-size payload and publishes held fields on a strobe.
module packet_rx
    import packet_pkg::*;
#(
    parameter int PAYLOAD_BYTES  = 32,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [7:0]                 rx_data,
    input  logic                       rx_valid,
    output logic [7:0]                 cmd,
    output logic [15:0]                len,
    output logic [8*PAYLOAD_BYTES-1:0] payload,
    output logic                       packet_valid,
    output logic                       frame_error,
    output logic [1:0]                 err_code,
    output logic                       busy
);

    localparam int PL_W   = 8 * PAYLOAD_BYTES;
    localparam int CNT_W  = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [15:0]       MAX_LEN   = 16'(PAYLOAD_BYTES);
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    state_e              state, state_next;
    logic [7:0]          cmd_sh;
    logic [15:0]         lena_sh;
    logic [7:0]          lenb_hi;
    logic [15:0]         lenb;
    logic [PL_W-1:0]     pl_sh, pl_next;
    logic [CNT_W-1:0]    byte_cnt;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                in_frame, timeout_hit, abort, done;
    logic [1:0]          abort_code;

    assign in_frame    = (state != ST_SYNC0) && (state != ST_SYNC1);
    // An arriving byte always beats the timeout on the same cycle.
    assign timeout_hit = in_frame && !rx_valid && (idle_cnt == IDLE_LAST);
    assign lenb        = {lenb_hi, rx_data};
    assign pl_next     = PL_W'({pl_sh, rx_data});

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        done       = 1'b0;
        if (timeout_hit) begin
            abort      = 1'b1;
            abort_code = ERR_TIMEOUT;
            state_next = ST_SYNC0;
        end else if (rx_valid) begin
            case (state)
                ST_SYNC0:  if (rx_data == SYNC0_BYTE) state_next = ST_SYNC1;
                ST_SYNC1: begin
                    if (rx_data == SYNC1_BYTE)      state_next = ST_CMD;
                    else if (rx_data != SYNC0_BYTE) state_next = ST_SYNC0;
                end
                ST_CMD:    state_next = ST_LENA_H;
                ST_LENA_H: state_next = ST_LENA_L;
                ST_LENA_L: state_next = ST_LENB_H;
                ST_LENB_H: state_next = ST_LENB_L;
                ST_LENB_L: begin
                    if (lenb != lena_sh) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN_MISMATCH;
                        state_next = ST_SYNC0;
                    end else if (lena_sh > MAX_LEN) begin
                        abort      = 1'b1;
                        abort_code = ERR_LEN_RANGE;
                        state_next = ST_SYNC0;
                    end else begin
                        state_next = ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (byte_cnt == LAST_IDX) begin
                        done       = 1'b1;
                        state_next = ST_SYNC0;
                    end
                end
                default:   state_next = ST_SYNC0;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_SYNC0;
            cmd_sh       <= '0;
            lena_sh      <= '0;
            lenb_hi      <= '0;
            pl_sh        <= '0;
            byte_cnt     <= '0;
            idle_cnt     <= '0;
            cmd          <= '0;
            len          <= '0;
            payload      <= '0;
            err_code     <= ERR_NONE;
            packet_valid <= 1'b0;
            frame_error  <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            busy         <= (state_next != ST_SYNC0);
            packet_valid <= done;
            frame_error  <= abort;
            if (abort) err_code <= abort_code;

            if (rx_valid) begin
                case (state)
                    ST_CMD:     cmd_sh        <= rx_data;
                    ST_LENA_H:  lena_sh[15:8] <= rx_data;
                    ST_LENA_L:  lena_sh[7:0]  <= rx_data;
                    ST_LENB_H:  lenb_hi       <= rx_data;
                    ST_PAYLOAD: pl_sh         <= pl_next;
                    default: ;
                endcase
            end

            if (done) begin
                cmd     <= cmd_sh;
                len     <= lena_sh;
                payload <= pl_next;
            end

            if (rx_valid || !in_frame || timeout_hit) idle_cnt <= '0;
            else                                      idle_cnt <= idle_cnt + 1'b1;

            if (state_next != ST_PAYLOAD)             byte_cnt <= '0;
            else if (state == ST_PAYLOAD && rx_valid) byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_packet_rx.sv
// Directed bench for packet_rx: expected strobes go into a scoreboard queue,
// a negedge monitor pops and compares each packet_valid / frame_error.
module tb_packet_rx;

    localparam int PB = 32;
    localparam int TO = 50;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    cmd;
    logic [15:0]   len;
    logic [8*PB-1:0] payload;
    logic          packet_valid, frame_error, busy;
    logic [1:0]    err_code;

    packet_rx #(.PAYLOAD_BYTES(PB), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .cmd(cmd), .len(len), .payload(payload), .packet_valid(packet_valid),
        .frame_error(frame_error), .err_code(err_code), .busy(busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit           is_err;
        logic [7:0]   cmd;
        logic [15:0]  len;
        logic [255:0] pl;
        logic [1:0]   code;
    } exp_t;

    exp_t q[$];
    int vectors    = 0;
    int miscompares = 0;

    localparam logic [255:0] PL0 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] PL1 = 256'hffeeddccbbaa99887766554433221100_0123456789abcdeffedcba9876543210;
    localparam logic [255:0] PL2 = 256'hdeadbeef_cafef00d_01020304_a5a5a5a5_5a5a5a5a_55aa55aa_00000000_ffffffff;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_good(input logic [7:0] c, input logic [15:0] l, input logic [255:0] p);
        exp_t e;
        e.is_err = 1'b0; e.cmd = c; e.len = l; e.pl = p; e.code = 2'd0;
        q.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.cmd = '0; e.len = '0; e.pl = '0; e.code = code;
        q.push_back(e);
    endtask

    always @(negedge clock) begin
        if (!reset && (packet_valid || frame_error)) begin
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got pv=%0b fe=%0b want none", packet_valid, frame_error);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sb_kind_pv", 256'(packet_valid), 256'(!e.is_err));
                chk("sb_kind_fe", 256'(frame_error), 256'(e.is_err));
                if (e.is_err) begin
                    chk("sb_err_code", 256'(err_code), 256'(e.code));
                end else begin
                    chk("sb_cmd", 256'(cmd), 256'(e.cmd));
                    chk("sb_len", 256'(len), 256'(e.len));
                    chk("sb_payload", payload, e.pl);
                end
            end
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock); #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic send_body(input logic [7:0] c, input logic [15:0] la, input logic [15:0] lb,
                             input logic [255:0] pl, input int n_pl, input int stall_at, input int stall_len);
        send(c);
        send(la[15:8]); send(la[7:0]);
        send(lb[15:8]); send(lb[7:0]);
        for (int i = 0; i < n_pl; i++) begin
            send(pl[255-8*i -: 8]);
            if (i == stall_at) idle(stall_len);
        end
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [15:0] l, input logic [255:0] pl);
        send(8'h55); send(8'hAA);
        send_body(c, l, l, pl, PB, -1, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
        idle(3);
        reset = 1'b0;
        chk("rst_cmd", 256'(cmd), 256'(0));
        chk("rst_len", 256'(len), 256'(0));
        chk("rst_payload", payload, 256'(0));
        chk("rst_err_code", 256'(err_code), 256'(0));
        chk("rst_pv", 256'(packet_valid), 256'(0));
        chk("rst_fe", 256'(frame_error), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));

        // Good packet, payload 00..1F
        push_good(8'h3C, 16'h0010, PL0);
        send_pkt(8'h3C, 16'h0010, PL0);
        chk("t1_pv_latency", 256'(packet_valid), 256'(1));
        chk("t1_pl_msb", 256'(payload[255:248]), 256'(8'h00));
        chk("t1_pl_lsb", 256'(payload[7:0]), 256'(8'h1F));
        chk("t1_busy_idle", 256'(busy), 256'(0));
        idle(1);
        chk("t1_pv_one_cycle", 256'(packet_valid), 256'(0));

        // Garbage and repeated sync, then len at the upper bound
        send(8'hFF); send(8'h55); send(8'h55);
        chk("t2_busy_sync1", 256'(busy), 256'(1));
        send(8'hAA);
        push_good(8'h5A, 16'h0020, PL1);
        send_body(8'h5A, 16'h0020, 16'h0020, PL1, PB, -1, 0);

        // Length copies differ
        push_err(2'd1);
        send(8'h55); send(8'hAA);
        send_body(8'h01, 16'h0004, 16'h0005, PL0, 0, -1, 0);
        chk("t3_fe_edge", 256'(frame_error), 256'(1));
        chk("t3_err_code", 256'(err_code), 256'(1));
        chk("t3_cmd_held", 256'(cmd), 256'(8'h5A));
        chk("t3_len_held", 256'(len), 256'(16'h0020));
        chk("t3_pl_held", payload, PL1);
        push_good(8'h11, 16'h0001, PL2);
        send_pkt(8'h11, 16'h0001, PL2);

        // Length above payload size
        push_err(2'd2);
        send(8'h55); send(8'hAA);
        send_body(8'h02, 16'h0021, 16'h0021, PL0, 0, -1, 0);
        chk("t4_err_code", 256'(err_code), 256'(2));
        chk("t4_busy", 256'(busy), 256'(0));
        chk("t4_cmd_held", 256'(cmd), 256'(8'h11));

        // Timeout after the cmd byte
        push_err(2'd3);
        send(8'h55); send(8'hAA); send(8'h07);
        idle(TO - 1);
        chk("t5_no_fe_early", 256'(frame_error), 256'(0));
        idle(1);
        chk("t5_fe_at_limit", 256'(frame_error), 256'(1));
        chk("t5_err_code", 256'(err_code), 256'(3));
        chk("t5_busy", 256'(busy), 256'(0));
        chk("t5_cmd_held", 256'(cmd), 256'(8'h11));

        // 49-cycle stall mid-payload: byte arrives on the would-be timeout cycle
        push_good(8'h22, 16'h0008, PL0);
        send(8'h55); send(8'hAA);
        send_body(8'h22, 16'h0008, 16'h0008, PL0, PB, 5, TO - 1);

        // Reset during payload byte 10, then a clean packet
        send(8'h55); send(8'hAA);
        send_body(8'h33, 16'h0004, 16'h0004, PL2, 10, -1, 0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("t6_rst_cmd", 256'(cmd), 256'(0));
        chk("t6_rst_payload", payload, 256'(0));
        chk("t6_rst_err", 256'(err_code), 256'(0));
        chk("t6_rst_busy", 256'(busy), 256'(0));
        push_good(8'h44, 16'h0020, PL1);
        send(8'h55); send(8'hAA);
        send_body(8'h44, 16'h0020, 16'h0020, PL1, PB - 1, -1, 0);
        chk("t6_cmd_still0", 256'(cmd), 256'(0));
        chk("t6_len_still0", 256'(len), 256'(0));
        send(PL1[7:0]);
        chk("t6_pv", 256'(packet_valid), 256'(1));

        idle(3);
        chk("sb_drained", 256'(q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/packet_rx.md
# packet_rx

Receive-side packet framer for the UART link. It consumes the byte stream from the UART receiver and finds the sync pattern. It then parses the command, a redundant length field and a fixed-size payload, and presents each complete, validated packet to the command decoder as a single-cycle strobe with held fields. Its wire format is the same one the transmit-side packet framer produces.

## Interface
- `PAYLOAD_BYTES`, default 32: payload bytes per packet. The payload field on the wire is always this size, whatever `len` says.
- `TIMEOUT_CYCLES`, default 100000: maximum idle clocks between bytes inside a packet before the framer aborts it.
- `clock` in 1: the only clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte, qualified by `rx_valid`.
- `rx_valid` in 1: one-cycle strobe, one byte per strobe.
- `cmd` out 8: command of the last good packet.
- `len` out 16: length of the last good packet.
- `payload` out 8*PAYLOAD_BYTES: payload of the last good packet. The first payload byte on the wire lands in the MSB byte.
- `packet_valid` out 1: one-cycle strobe marking a new good packet.
- `frame_error` out 1: one-cycle strobe marking an aborted packet.
- `err_code` out 2: reason for the last abort. 1 = length copies differ, 2 = len > PAYLOAD_BYTES, 3 = inter-byte timeout.
- `busy` out 1: high in every state except SYNC0.

## Operation
- Wire order:
  - 0x55, 0xAA
  - cmd
  - len[15:8], len[7:0] (copy A)
  - len[15:8], len[7:0] (copy B)
  - PAYLOAD_BYTES payload bytes
- FSM advances one state per accepted byte. States: SYNC0, SYNC1, CMD, LENA_H, LENA_L, LENB_H, LENB_L, PAYLOAD.
- SYNC0: byte 0x55 goes to SYNC1. Any other byte is dropped and the FSM stays in SYNC0.
- SYNC1:
  - 0xAA goes to CMD.
  - 0x55 stays in SYNC1 (handles a repeated sync byte).
  - Anything else goes to SYNC0.
  - No error is raised in SYNC1.
- CMD and the four length states capture their bytes into shadow registers.
- LENB_L compares copy A with copy B.
  - Copies differ: error code 1.
  - Copies match but A > PAYLOAD_BYTES: error code 2.
  - Otherwise the FSM enters PAYLOAD.
- PAYLOAD: a byte counter runs 0..PAYLOAD_BYTES-1. Each byte shifts into the shadow payload from the LSB side, so the first byte ends up in the MSB byte.
  - After the last byte the shadow cmd, len and payload copy to the outputs in one cycle.
  - `packet_valid` pulses and the FSM returns to SYNC0.
- Abort: `frame_error` pulses, `err_code` is updated, the FSM goes to SYNC0, and output fields are not modified.
- Timeout:
  - An idle counter clears on every `rx_valid`.
  - It counts only while the FSM is in CMD..PAYLOAD.
  - Reaching TIMEOUT_CYCLES gives error code 3.
- The aborting byte is never re-examined as a sync byte. The exception is SYNC1, which treats 0x55 as a fresh sync.

## Timing
- Reset values:
  - FSM in SYNC0, counters at 0.
  - `cmd`, `len`, `payload`, `err_code` = 0.
  - `packet_valid`, `frame_error`, `busy` = 0.
- All outputs are registered.
- `packet_valid` is high in the cycle after the clock edge that accepted the last payload byte, for exactly one cycle. The fields update on that same edge and then hold until the next good packet.
- `frame_error` and `err_code` update on the edge that detects the fault. For errors 1 and 2 that is the edge accepting len copy B low byte. For error 3 it is the edge where the idle count reaches TIMEOUT_CYCLES.
- `rx_valid` may arrive back-to-back, every cycle. No backpressure exists and no byte is dropped.
- `rx_valid` on the same cycle as the timeout: the byte wins and the timeout is suppressed.
- `reset` mid-packet: the partial packet is discarded silently, with no `frame_error`. Held outputs clear to 0.

## Structure
- Shared package `packet_pkg` holds:
  - SYNC0_BYTE = 8'h55, SYNC1_BYTE = 8'hAA
  - the FSM state enum
  - the err_code constants
  - HEADER_BYTES = 7
- packet_tx uses the same package.
- No sub-module. The idle-timeout counter is a small, natural candidate to split out as `idle_timer` if a second user appears.

## Test plan
- Good packet: 55 AA 3C 00 10 00 10 followed by 32 bytes 00..1F.
  - Expect one `packet_valid` pulse.
  - cmd=3C, len=0x0010, payload[255:248]=00, payload[7:0]=1F.
- Garbage then a repeated sync: FF 55 55 AA followed by a valid packet. Expect exactly one good packet and no `frame_error`.
- Length mismatch: 55 AA 01 00 04 00 05.
  - `frame_error` on the edge that accepts the byte 05, err_code=1.
  - Outputs unchanged.
  - The following good packet is accepted.
- Length too large: len copies both 0x0021 → err_code=2, FSM back in SYNC0.
- Timeout with TIMEOUT_CYCLES=50: stop after the CMD byte.
  - `frame_error` with err_code=3 exactly 50 cycles after the last `rx_valid`.
  - A stall of 49 cycles mid-payload gives no error.
- Reset mid-payload (byte 10 of 32), then a full good packet → no `frame_error`, outputs read 0 until the new packet's `packet_valid`.
